// File: rtl/abfn_rst_pkg.sv
// Shared types and default timing constants for the CCC-downstream reset sequencer.
package abfn_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_LOCK_STABLE,
        ST_MSS_WAIT,
        ST_FAB_DELAY,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_LOCK_LOSS_FILTER   = 4;
    localparam int DEF_FAB_RELEASE_DELAY  = 16;
    localparam int DEF_MSS_READY_TIMEOUT  = 65535;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/abfn_sync_ff.sv
// Single-bit multi-flop synchronizer with asynchronous clear to 0.
module abfn_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/abfn_clk_reset_sequencer.sv
// Releases MSS then fabric reset once CCC lock is stable; re-asserts both on filtered lock loss.
module abfn_clk_reset_sequencer
    import abfn_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_LOSS_FILTER   = DEF_LOCK_LOSS_FILTER,
    parameter int FAB_RELEASE_DELAY  = DEF_FAB_RELEASE_DELAY,
    parameter int MSS_READY_TIMEOUT  = DEF_MSS_READY_TIMEOUT
) (
    input  logic       CLK_BASE,
    input  logic       POWER_ON_RESET_N,
    input  logic       LOCK,
    input  logic       MSS_READY,
    input  logic       RETRY,
    output logic       MSS_RESET_N_F2M,
    output logic       FAB_RESET_N,
    output logic       INIT_DONE,
    output logic       FAULT,
    output logic [7:0] LOCK_LOSS_COUNT
);

    // Loss filter shares the counter width so its limit can never overflow it.
    localparam int CNT_W = $clog2(max_int(max_int(LOCK_STABLE_CYCLES, FAB_RELEASE_DELAY),
                                          max_int(MSS_READY_TIMEOUT, LOCK_LOSS_FILTER))) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MSS_READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FAB_LAST     = CNT_W'(FAB_RELEASE_DELAY - 1);
    localparam logic [CNT_W-1:0] LOSS_LIMIT   = CNT_W'(LOCK_LOSS_FILTER);

    logic             w_lock_s;
    logic             w_rdy_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lost;
    logic             w_cnt_inc;
    logic             w_monitor;
    logic             w_loss;
    logic             r_mss_rst_n;
    logic             r_fab_rst_n;
    logic             r_init_done;
    logic             r_fault;
    logic [7:0]       r_loss_cnt;

    abfn_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .i_clk   (CLK_BASE),
        .i_rst_n (POWER_ON_RESET_N),
        .i_d     (LOCK),
        .o_q     (w_lock_s)
    );

    abfn_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy (
        .i_clk   (CLK_BASE),
        .i_rst_n (POWER_ON_RESET_N),
        .i_d     (MSS_READY),
        .o_q     (w_rdy_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        w_monitor   = (r_state == ST_MSS_WAIT) || (r_state == ST_FAB_DELAY) || (r_state == ST_RUN);
        w_loss      = w_monitor && (r_lost == LOSS_LIMIT);
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) w_state_nxt = ST_LOCK_STABLE;
            end
            ST_LOCK_STABLE: begin
                if (!w_lock_s)                  w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == STABLE_LAST)  w_state_nxt = ST_MSS_WAIT;
                else                            w_cnt_inc   = 1'b1;
            end
            // Lock loss outranks both ready and timeout here.
            ST_MSS_WAIT: begin
                if (w_loss)                     w_state_nxt = ST_WAIT_LOCK;
                else if (w_rdy_s)               w_state_nxt = ST_FAB_DELAY;
                else if (r_cnt == TIMEOUT_LAST) w_state_nxt = ST_FAULT;
                else                            w_cnt_inc   = 1'b1;
            end
            ST_FAB_DELAY: begin
                if (w_loss)                     w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == FAB_LAST)     w_state_nxt = ST_RUN;
                else                            w_cnt_inc   = 1'b1;
            end
            ST_RUN: begin
                if (w_loss) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_FAULT: begin
                if (RETRY) w_state_nxt = ST_WAIT_LOCK;
            end
            default: w_state_nxt = ST_WAIT_LOCK;
        endcase
    end

    always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_lost      <= '0;
            r_mss_rst_n <= 1'b0;
            r_fab_rst_n <= 1'b0;
            r_init_done <= 1'b0;
            r_fault     <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)  r_cnt <= '0;
            else if (w_cnt_inc)          r_cnt <= r_cnt + CNT_W'(1);
            if ((w_state_nxt != r_state) || w_lock_s)      r_lost <= '0;
            else if (w_monitor && (r_lost != LOSS_LIMIT))  r_lost <= r_lost + CNT_W'(1);
            // Outputs decoded from the next state so each one comes straight off a flop.
            r_mss_rst_n <= (w_state_nxt == ST_MSS_WAIT) || (w_state_nxt == ST_FAB_DELAY) ||
                           (w_state_nxt == ST_RUN);
            r_fab_rst_n <= (w_state_nxt == ST_RUN);
            r_init_done <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
            if (w_loss && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign MSS_RESET_N_F2M = r_mss_rst_n;
    assign FAB_RESET_N     = r_fab_rst_n;
    assign INIT_DONE       = r_init_done;
    assign FAULT           = r_fault;
    assign LOCK_LOSS_COUNT = r_loss_cnt;

endmodule

// File: tb/tb_abfn_clk_reset_sequencer.sv
// Self-checking bench for abfn_clk_reset_sequencer: per-cycle vector tables plus hand-written corner sequences.
module tb_abfn_clk_reset_sequencer;

    logic       CLK_BASE = 1'b0;
    logic       POWER_ON_RESET_N;
    logic       LOCK;
    logic       MSS_READY;
    logic       RETRY;
    logic       MSS_RESET_N_F2M;
    logic       FAB_RESET_N;
    logic       INIT_DONE;
    logic       FAULT;
    logic [7:0] LOCK_LOSS_COUNT;
    logic [11:0] w_got;

    // Expected word layout: {mss_rst_n, fab_rst_n, init_done, fault, loss_count[7:0]}
    typedef struct {
        int          n;
        logic        lock;
        logic        rdy;
        logic        retry;
        logic [11:0] want;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    string       scen  = "init";

    abfn_clk_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_LOSS_FILTER   (4),
        .FAB_RELEASE_DELAY  (3),
        .MSS_READY_TIMEOUT  (20)
    ) dut (
        .CLK_BASE         (CLK_BASE),
        .POWER_ON_RESET_N (POWER_ON_RESET_N),
        .LOCK             (LOCK),
        .MSS_READY        (MSS_READY),
        .RETRY            (RETRY),
        .MSS_RESET_N_F2M  (MSS_RESET_N_F2M),
        .FAB_RESET_N      (FAB_RESET_N),
        .INIT_DONE        (INIT_DONE),
        .FAULT            (FAULT),
        .LOCK_LOSS_COUNT  (LOCK_LOSS_COUNT)
    );

    always #5 CLK_BASE = ~CLK_BASE;

    assign w_got = {MSS_RESET_N_F2M, FAB_RESET_N, INIT_DONE, FAULT, LOCK_LOSS_COUNT};

    function automatic logic [11:0] ex(input logic [3:0] o, input int c);
        return {o, 8'(c)};
    endfunction

    function automatic void add(input int n, input logic lock, input logic rdy,
                                input logic retry, input logic [11:0] want);
        vec_t v;
        v.n = n; v.lock = lock; v.rdy = rdy; v.retry = retry; v.want = want;
        tbl.push_back(v);
    endfunction

    task automatic check_now(input string name, input logic [11:0] want);
        n_vec++;
        if (w_got !== want) begin
            n_err++;
            $display("FAIL %s #%0d: got mss=%b fab=%b done=%b fault=%b cnt=%0d, want mss=%b fab=%b done=%b fault=%b cnt=%0d",
                     name, n_vec, w_got[11], w_got[10], w_got[9], w_got[8], w_got[7:0],
                     want[11], want[10], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic cyc(input logic lock, input logic rdy, input logic retry,
                       input bit chk, input logic [11:0] want);
        logic [11:0] e;
        @(negedge CLK_BASE);
        LOCK = lock; MSS_READY = rdy; RETRY = retry;
        if (chk) sb.push_back(want);
        @(posedge CLK_BASE);
        #1;
        if (chk) begin
            e = sb.pop_front();
            check_now(scen, e);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++)
            for (int k = 0; k < tbl[i].n; k++)
                cyc(tbl[i].lock, tbl[i].rdy, tbl[i].retry, 1'b1, tbl[i].want);
        tbl.delete();
    endtask

    task automatic do_reset();
        LOCK = 1'b0; MSS_READY = 1'b0; RETRY = 1'b0;
        POWER_ON_RESET_N = 1'b0;
        repeat (3) @(posedge CLK_BASE);
        #1;
        check_now({scen, "_reset"}, 12'h000);
        @(negedge CLK_BASE);
        POWER_ON_RESET_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] Z, M, R, F;
        Z = ex(4'b0000, 0);
        M = ex(4'b1000, 0);
        R = ex(4'b1110, 0);
        F = ex(4'b0001, 0);

        // Nominal bring-up, RETRY/MSS_READY ignored in RUN, then lock glitches in RUN
        scen = "nominal";
        do_reset();
        add(10, 1'b0, 1'b0, 1'b0, Z);
        add(10, 1'b1, 1'b0, 1'b0, Z);
        add(5,  1'b1, 1'b0, 1'b0, M);
        add(5,  1'b1, 1'b1, 1'b0, M);
        add(3,  1'b1, 1'b1, 1'b0, R);
        add(1,  1'b1, 1'b1, 1'b1, R);
        add(2,  1'b1, 1'b0, 1'b0, R);
        add(3,  1'b0, 1'b1, 1'b0, R);
        add(6,  1'b1, 1'b1, 1'b0, R);
        add(4,  1'b0, 1'b1, 1'b0, R);
        add(2,  1'b1, 1'b1, 1'b0, R);
        add(9,  1'b1, 1'b1, 1'b0, ex(4'b0000, 1));
        add(4,  1'b1, 1'b1, 1'b0, ex(4'b1000, 1));
        add(3,  1'b1, 1'b1, 1'b0, ex(4'b1110, 1));
        run_tbl();

        // One-cycle LOCK drop at qualification count 5 restarts qualification
        scen = "qual_glitch";
        do_reset();
        add(6,  1'b1, 1'b0, 1'b0, Z);
        add(1,  1'b0, 1'b0, 1'b0, Z);
        add(10, 1'b1, 1'b0, 1'b0, Z);
        add(3,  1'b1, 1'b0, 1'b0, M);
        run_tbl();

        // MSS_READY never arrives: FAULT 20 cycles after MSS release, LOCK ignored, RETRY reruns
        scen = "timeout";
        do_reset();
        add(10, 1'b1, 1'b0, 1'b0, Z);
        add(20, 1'b1, 1'b0, 1'b0, M);
        add(3,  1'b1, 1'b0, 1'b0, F);
        add(3,  1'b0, 1'b0, 1'b0, F);
        add(2,  1'b1, 1'b0, 1'b0, F);
        add(1,  1'b1, 1'b0, 1'b1, Z);
        add(8,  1'b1, 1'b0, 1'b0, Z);
        add(3,  1'b1, 1'b0, 1'b0, M);
        run_tbl();

        // Power-on reset pulsed during FAB_DELAY: outputs clear before the next clock edge
        scen = "mid_reset";
        do_reset();
        add(10, 1'b1, 1'b1, 1'b0, Z);
        add(2,  1'b1, 1'b1, 1'b0, M);
        run_tbl();
        #2;
        POWER_ON_RESET_N = 1'b0;
        #1;
        check_now("mid_reset_async", 12'h000);
        do_reset();
        add(10, 1'b1, 1'b1, 1'b0, Z);
        add(4,  1'b1, 1'b1, 1'b0, M);
        add(3,  1'b1, 1'b1, 1'b0, R);
        run_tbl();

        // 300 filtered lock-loss events from MSS_WAIT; counter must stick at 255
        scen = "saturate";
        do_reset();
        for (int ev = 1; ev <= 300; ev++) begin
            repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, Z);
            repeat (7)  cyc(1'b0, 1'b0, 1'b0, 1'b0, Z);
            cyc(1'b0, 1'b0, 1'b0, (ev == 1) || (ev == 254) || (ev == 300),
                ex(4'b0000, (ev > 255) ? 255 : ev));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
